ae_memorizer: RTL and testbench

Acquisition-side writer for the ping-pong channel memory that the serial readout FSM drains. It detects an acoustic-emission (AE) event on the discriminated trigger and writes one channel-hit word per sample tick into alternating 200-word banks. It reports each completely filled bank with bank0_full/bank1_full, and reports the end of an event with memorization_completed plus idx_final. It sits directly upstream of the readout FSM and the dual-bank RAM.

---
 rtl/ae_memorizer.sv | 151 +++++++++++++++
 tb/tb_ae_memorizer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ae_memorizer.sv
// AE event memorizer: captures one channel-hit word per sample tick into
// alternating DEPTH-word RAM banks, flagging full banks and event completion.
module ae_memorizer #(
  parameter int CH_W    = 16,
  parameter int DEPTH   = 200,
  parameter int END_GAP = 4,
  parameter int HOLDOFF = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            sample_tick,
  input  logic            trigger,
  input  logic [CH_W-1:0] ch_in,
  output logic            we,
  output logic [8:0]      waddr,
  output logic [CH_W-1:0] wdata,
  output logic            bank0_full,
  output logic            bank1_full,
  output logic            memorization_completed,
  output logic [7:0]      idx_final,
  output logic            recording
);

  localparam int GAP_W  = $clog2(END_GAP + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam logic [7:0]        LAST_IDX = 8'(DEPTH - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(END_GAP);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLDOFF);

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_HOLDOFF} state_t;

  state_t            state, state_nxt;
  logic [7:0]        idx, idx_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt, gap_sat;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_sat;

  logic              we_nxt, b0_nxt, b1_nxt, mc_nxt, rec_nxt;
  logic [8:0]        waddr_nxt;
  logic [CH_W-1:0]   wdata_nxt;
  logic [7:0]        idx_final_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= S_IDLE;
      idx                    <= '0;
      wr_bank                <= 1'b0;
      gap_cnt                <= '0;
      hold_cnt               <= '0;
      we                     <= 1'b0;
      waddr                  <= '0;
      wdata                  <= '0;
      bank0_full             <= 1'b0;
      bank1_full             <= 1'b0;
      memorization_completed <= 1'b0;
      idx_final              <= '0;
      recording              <= 1'b0;
    end else begin
      state                  <= state_nxt;
      idx                    <= idx_nxt;
      wr_bank                <= wr_bank_nxt;
      gap_cnt                <= gap_nxt;
      hold_cnt               <= hold_nxt;
      we                     <= we_nxt;
      waddr                  <= waddr_nxt;
      wdata                  <= wdata_nxt;
      bank0_full             <= b0_nxt;
      bank1_full             <= b1_nxt;
      memorization_completed <= mc_nxt;
      idx_final              <= idx_final_nxt;
      recording              <= rec_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    wr_bank_nxt   = wr_bank;
    gap_nxt       = gap_cnt;
    hold_nxt      = hold_cnt;
    we_nxt        = 1'b0;
    waddr_nxt     = waddr;
    wdata_nxt     = wdata;
    b0_nxt        = 1'b0;
    b1_nxt        = 1'b0;
    mc_nxt        = 1'b0;
    idx_final_nxt = idx_final;
    gap_sat       = (gap_cnt == GAP_END) ? gap_cnt : gap_cnt + GAP_W'(1);
    hold_sat      = (hold_cnt == HOLD_END) ? hold_cnt : hold_cnt + HOLD_W'(1);

    case (state)
      S_IDLE: begin
        if (sample_tick && trigger && enable) begin
          we_nxt    = 1'b1;
          waddr_nxt = {wr_bank, 8'd0};
          wdata_nxt = ch_in;
          idx_nxt   = 8'd1;
          gap_nxt   = '0;
          state_nxt = S_RECORD;
        end
      end

      S_RECORD: begin
        if (!enable) begin
          // Forced end: idx==0 means the last write already flipped the bank.
          mc_nxt        = 1'b1;
          idx_final_nxt = idx;
          if (idx != 8'd0) wr_bank_nxt = ~wr_bank;
          idx_nxt       = '0;
          hold_nxt      = '0;
          state_nxt     = S_HOLDOFF;
        end else if (sample_tick) begin
          we_nxt    = 1'b1;
          waddr_nxt = {wr_bank, idx};
          wdata_nxt = ch_in;
          gap_nxt   = trigger ? '0 : gap_sat;
          if (idx == LAST_IDX) begin
            b0_nxt      = ~wr_bank;
            b1_nxt      = wr_bank;
            idx_nxt     = '0;
            wr_bank_nxt = ~wr_bank;
          end else begin
            idx_nxt = idx + 8'd1;
          end
          // The gap-closing tick is still written; next event uses the other bank.
          if (!trigger && (gap_sat == GAP_END)) begin
            mc_nxt        = 1'b1;
            idx_final_nxt = idx + 8'd1;
            wr_bank_nxt   = ~wr_bank;
            idx_nxt       = '0;
            hold_nxt      = '0;
            state_nxt     = S_HOLDOFF;
          end
        end
      end

      S_HOLDOFF: begin
        if (sample_tick) begin
          hold_nxt = hold_sat;
          if (hold_sat == HOLD_END) state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    rec_nxt = (state_nxt == S_RECORD);
  end

endmodule

// File: tb/tb_ae_memorizer.sv
// Directed bench for ae_memorizer: table of event scenarios plus hand-written
// holdoff, idle-enable and asynchronous-reset sequences.
module tb_ae_memorizer;
  localparam int CH_W = 16;
  localparam int W    = 3 + 9 + CH_W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            sample_tick = 1'b0;
  logic            trigger = 1'b0;
  logic [CH_W-1:0] ch_in = '0;
  logic            we;
  logic [8:0]      waddr;
  logic [CH_W-1:0] wdata;
  logic            bank0_full, bank1_full, memorization_completed;
  logic [7:0]      idx_final;
  logic            recording;

  ae_memorizer #(.CH_W(CH_W), .DEPTH(200), .END_GAP(4), .HOLDOFF(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
    .trigger(trigger), .ch_in(ch_in), .we(we), .waddr(waddr), .wdata(wdata),
    .bank0_full(bank0_full), .bank1_full(bank1_full),
    .memorization_completed(memorization_completed), .idx_final(idx_final),
    .recording(recording)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0, mc_cnt = 0, b0_cnt = 0, b1_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic         m_bank;
  logic [7:0]   m_idx;

  typedef struct {
    int         hi1;
    int         lo1;
    int         hi2;
    int         lo2;
    bit         drop;
    logic [8:0] start;
    int         writes;
    logic [7:0] fin;
    int         b0;
    int         b1;
  } vec_t;

  vec_t vecs[7];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // scoreboard: every write must match the next expected {flags, addr, data}
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got waddr=%0h expected no write (t=%0t)", waddr, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write", 32'({bank0_full, bank1_full, memorization_completed, waddr, wdata}), 32'(e));
        end
      end else if (bank0_full || bank1_full) begin
        total++;
        bad++;
        $display("FAIL full_without_write: got b0=%0b b1=%0b expected 0 (t=%0t)", bank0_full, bank1_full, $time);
      end
      if (memorization_completed) mc_cnt++;
      if (bank0_full) b0_cnt++;
      if (bank1_full) b1_cnt++;
    end
  endtask

  // driver: one sample tick followed by one quiet cycle
  task automatic do_tick(input logic trig, input logic en, input logic exp_wr, input logic exp_mc);
    logic [CH_W-1:0] d;
    logic            last;
    d = 16'($urandom_range(0, 65535));
    sample_tick = 1'b1;
    trigger     = trig;
    enable      = en;
    ch_in       = d;
    if (exp_wr) begin
      last = (m_idx == 8'd199);
      exp_q.push_back({last && !m_bank, last && m_bank, exp_mc, m_bank, m_idx, d});
      if (last) begin
        m_idx  = 8'd0;
        m_bank = ~m_bank;
      end else begin
        m_idx = m_idx + 8'd1;
      end
    end
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(negedge clk); #1;
    if (exp_wr) chk("write_latency", 32'(exp_q.size()), 32'd0);
    chk("completion", 32'(memorization_completed), 32'(exp_mc));
    chk("recording", 32'(recording), 32'(exp_wr && !exp_mc));
    @(posedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic idle_ticks(input int k);
    for (int i = 0; i < k; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input logic [7:0] prev_fin);
    int n, w0, mc0, b00, b10;
    idle_ticks(10);
    chk("idx_final_hold", 32'(idx_final), 32'(prev_fin));
    m_bank = v.start[8];
    m_idx  = v.start[7:0];
    w0  = wr_cnt;
    mc0 = mc_cnt;
    b00 = b0_cnt;
    b10 = b1_cnt;
    n = v.hi1 + v.lo1 + v.hi2 + v.lo2;
    for (int i = 0; i < n; i++) begin
      logic t;
      t = (i < v.hi1) || ((i >= v.hi1 + v.lo1) && (i < v.hi1 + v.lo1 + v.hi2));
      do_tick(t, 1'b1, 1'b1, !v.drop && (i == n - 1));
    end
    if (v.drop) do_tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("writes", 32'(wr_cnt - w0), 32'(v.writes));
    chk("mc_count", 32'(mc_cnt - mc0), 32'd1);
    chk("idx_final", 32'(idx_final), 32'(v.fin));
    chk("b0_count", 32'(b0_cnt - b00), 32'(v.b0));
    chk("b1_count", 32'(b1_cnt - b10), 32'(v.b1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, mc0;
    //            hi1 lo1 hi2 lo2 drop start   writes fin  b0 b1
    vecs[0] = '{250, 0, 0, 4, 1'b0, 9'h000, 254, 8'd54,  1, 0}; // long, crosses bank 0
    vecs[1] = '{ 10, 0, 0, 4, 1'b0, 9'h000,  14, 8'd14,  0, 0}; // short
    vecs[2] = '{196, 0, 0, 4, 1'b0, 9'h100, 200, 8'd200, 0, 1}; // exact fill bank 1
    vecs[3] = '{196, 0, 0, 4, 1'b0, 9'h000, 200, 8'd200, 1, 0}; // exact fill bank 0
    vecs[4] = '{ 30, 0, 0, 0, 1'b1, 9'h100,  30, 8'd30,  0, 0}; // enable drop
    vecs[5] = '{200, 0, 0, 0, 1'b1, 9'h000, 200, 8'd0,   1, 0}; // drop right after fill
    vecs[6] = '{  3, 2, 3, 4, 1'b0, 9'h100,  12, 8'd12,  0, 0}; // gap restarted

    fork monitor(); join_none

    repeat (3) @(negedge clk);
    #1;
    chk("reset_addr_data", 32'({waddr, wdata}), 32'd0);
    chk("reset_flags", 32'({we, bank0_full, bank1_full, memorization_completed, recording, idx_final}), 32'd0);
    reset = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], (i == 0) ? 8'd0 : vecs[i-1].fin);

    // holdoff: trigger returns 2 ticks after completion; capture only on tick 9
    m_bank = 1'b0;
    m_idx  = 8'd0;
    w0 = wr_cnt;
    do_tick(1'b0, 1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("holdoff_no_write", 32'(wr_cnt - w0), 32'd0);
    do_tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1, 1'b1, 1'b0);
    do_tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("holdoff_idx_final", 32'(idx_final), 32'd5);

    // enable low in IDLE ignores trigger
    idle_ticks(10);
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_disabled_no_write", 32'(wr_cnt - w0), 32'd0);

    // asynchronous reset during the 100th write of an event in bank 1
    idle_ticks(10);
    m_bank = 1'b1;
    m_idx  = 8'd0;
    mc0 = mc_cnt;
    for (int i = 0; i < 99; i++) do_tick(1'b1, 1'b1, 1'b1, 1'b0);
    sample_tick = 1'b1;
    trigger     = 1'b1;
    ch_in       = 16'hBEEF;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    chk("we_before_reset", 32'({we, waddr}), 32'({1'b1, 9'h163}));
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_addr_data", 32'({waddr, wdata}), 32'd0);
    chk("async_reset_flags", 32'({we, bank0_full, bank1_full, memorization_completed, recording, idx_final}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    idle_ticks(10);
    chk("no_completion_after_reset", 32'(mc_cnt - mc0), 32'd0);
    m_bank = 1'b0;
    m_idx  = 8'd0;
    for (int i = 0; i < 9; i++) do_tick(i < 5, 1'b1, 1'b1, i == 8);
    chk("post_reset_idx_final", 32'(idx_final), 32'd9);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
